// File: rtl/issue_timing_sched_pkg.sv
// Shared types for the issue path: DRAM command encoding, FIFO entry layout, timing defaults.
// Unknown command encodings decode to CMD_NOP so the scheduler drops them harmlessly.
package userType_pkg;

   localparam int ISU_FIFO_WIDTH = 21;
   localparam int ADDR_W         = 14;
   localparam int BANK_W         = 3;

   localparam int T_RCD_DEF = 4;
   localparam int T_RP_DEF  = 4;
   localparam int T_RAS_DEF = 10;
   localparam int T_CCD_DEF = 2;
   localparam int T_RFC_DEF = 20;

   typedef enum logic [3:0] {
      CMD_NOP   = 4'd0,
      CMD_ACT   = 4'd1,
      CMD_READ  = 4'd2,
      CMD_WRITE = 4'd3,
      CMD_PRE   = 4'd4,
      CMD_REF   = 4'd5
   } sch_cmd_t;

   typedef struct packed {
      logic [3:0]        cmd;
      logic [ADDR_W-1:0] addr;
      logic [BANK_W-1:0] bank;
   } issue_fifo_cmd_in_t;

   function automatic sch_cmd_t decode_cmd(input logic [3:0] raw);
      sch_cmd_t c;
      c = CMD_NOP;
      case (raw)
         CMD_ACT, CMD_READ, CMD_WRITE, CMD_PRE, CMD_REF: c = sch_cmd_t'(raw);
         default: c = CMD_NOP;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/issue_timing_sched_bank_timer.sv
// Per-bank rcd/rp/ras countdown timers; a load on issue overrides the per-cycle decrement.
// Ready flags are combinational from the counters (zero means the dependent command is legal).
module bank_timer
   import userType_pkg::*;
#(
   parameter int CNT_W = 6,
   parameter int T_RCD = T_RCD_DEF,
   parameter int T_RP  = T_RP_DEF,
   parameter int T_RAS = T_RAS_DEF
)(
   input  logic clk,
   input  logic rst_n,
   input  logic ld_act,
   input  logic ld_pre,
   output logic rw_ok,
   output logic act_ok,
   output logic pre_ok
);

   logic [CNT_W-1:0] rcd;
   logic [CNT_W-1:0] rp;
   logic [CNT_W-1:0] ras;

   function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] v);
      return (v == '0) ? v : v - CNT_W'(1);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rcd <= '0;
         rp  <= '0;
         ras <= '0;
      end else begin
         rcd <= ld_act ? CNT_W'(T_RCD - 1) : dec_sat(rcd);
         ras <= ld_act ? CNT_W'(T_RAS - 1) : dec_sat(ras);
         rp  <= ld_pre ? CNT_W'(T_RP - 1)  : dec_sat(rp);
      end
   end

   assign rw_ok  = (rcd == '0);
   assign act_ok = (rp == '0);
   assign pre_ok = (ras == '0);

endmodule

// File: rtl/issue_timing_sched.sv
// Pops the issue FIFO head when DRAM timing allows and registers it onto the command bus (1-cycle latency).
// Stalls (no pop) while the head is blocked, while sched_en is low, and for the whole refresh window.
module issue_timing_sched
   import userType_pkg::*;
#(
   parameter int T_RCD = T_RCD_DEF,
   parameter int T_RP  = T_RP_DEF,
   parameter int T_RAS = T_RAS_DEF,
   parameter int T_CCD = T_CCD_DEF,
   parameter int T_RFC = T_RFC_DEF,
   parameter int CNT_W = 6,
   parameter int NBANK = 8
)(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [ISU_FIFO_WIDTH-1:0] fifo_head,
   input  logic                      fifo_empty,
   output logic                      fifo_ren,
   input  logic                      sched_en,
   output sch_cmd_t                  dram_cmd,
   output logic [ADDR_W-1:0]         dram_addr,
   output logic [BANK_W-1:0]         dram_bank,
   output logic                      dram_cmd_valid,
   output logic                      stall,
   output logic                      refresh_busy,
   output logic [15:0]               stall_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_ARB, S_REF} state_t;

   state_t             state;
   state_t             state_nxt;
   issue_fifo_cmd_in_t head;
   sch_cmd_t           cmd;
   logic [NBANK-1:0]   act_ok;
   logic [NBANK-1:0]   rw_ok;
   logic [NBANK-1:0]   pre_ok;
   logic [NBANK-1:0]   ld_act;
   logic [NBANK-1:0]   ld_pre;
   logic [CNT_W-1:0]   ccd;
   logic [CNT_W-1:0]   rfc;
   logic               legal;
   logic               run;
   logic               issue;

   assign head = issue_fifo_cmd_in_t'(fifo_head);
   assign cmd  = decode_cmd(head.cmd);

   always_comb begin
      legal = 1'b0;
      case (cmd)
         CMD_ACT:             legal = act_ok[head.bank];
         CMD_READ, CMD_WRITE: legal = rw_ok[head.bank] && (ccd == '0);
         CMD_PRE:             legal = pre_ok[head.bank];
         CMD_REF:             legal = &act_ok;
         default:             legal = 1'b1;
      endcase
      legal = legal && (rfc == '0);
   end

   // Gated by rst_n so nothing is popped from the FIFO while reset is held.
   assign run      = rst_n & sched_en & ~fifo_empty;
   assign issue    = run & legal & (state != S_REF);
   assign fifo_ren = issue;
   assign stall    = run & ~issue;

   always_comb begin
      ld_act = '0;
      ld_pre = '0;
      if (issue && cmd == CMD_ACT) ld_act[head.bank] = 1'b1;
      if (issue && cmd == CMD_PRE) ld_pre[head.bank] = 1'b1;
   end

   for (genvar b = 0; b < NBANK; b++) begin : g_bank
      bank_timer #(
         .CNT_W (CNT_W),
         .T_RCD (T_RCD),
         .T_RP  (T_RP),
         .T_RAS (T_RAS)
      ) u_bank_timer (
         .clk    (clk),
         .rst_n  (rst_n),
         .ld_act (ld_act[b]),
         .ld_pre (ld_pre[b]),
         .rw_ok  (rw_ok[b]),
         .act_ok (act_ok[b]),
         .pre_ok (pre_ok[b])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ccd <= '0;
         rfc <= '0;
      end else begin
         if (issue && (cmd == CMD_READ || cmd == CMD_WRITE)) ccd <= CNT_W'(T_CCD - 1);
         else if (ccd != '0)                                ccd <= ccd - CNT_W'(1);
         if (issue && cmd == CMD_REF) rfc <= CNT_W'(T_RFC - 1);
         else if (rfc != '0)          rfc <= rfc - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dram_cmd       <= CMD_NOP;
         dram_addr      <= '0;
         dram_bank      <= '0;
         dram_cmd_valid <= 1'b0;
      end else if (issue) begin
         dram_cmd       <= cmd;
         dram_addr      <= head.addr;
         dram_bank      <= head.bank;
         dram_cmd_valid <= (cmd != CMD_NOP);
      end else begin
         dram_cmd       <= CMD_NOP;
         dram_cmd_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        stall_cnt <= '0;
      else if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Leave S_REF one cycle early so the first post-refresh issue lands exactly T_RFC after REF.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (issue && cmd == CMD_REF)  state_nxt = S_REF;
                 else if (!fifo_empty && sched_en) state_nxt = S_ARB;
         S_ARB:  if (issue && cmd == CMD_REF)  state_nxt = S_REF;
                 else if (fifo_empty || !sched_en) state_nxt = S_IDLE;
         S_REF:  if (rfc <= CNT_W'(1))
                    state_nxt = (!fifo_empty && sched_en) ? S_ARB : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign refresh_busy = (state == S_REF);

endmodule
